// File: rtl/vending_machine_def.sv
// vending_machine_def: shared widths, state encodings and default coin/price tables
package vending_machine_def;
  localparam int kTotalBits = 31;
  localparam logic [1:0] kIdle   = 2'd0;
  localparam logic [1:0] kCredit = 2'd1;
  localparam logic [1:0] kReturn = 2'd2;
  localparam int kNCoin = 3;
  localparam int kNItem = 4;
  localparam logic [kNCoin*kTotalBits-1:0] kCoinTbl  = {31'd1000, 31'd500, 31'd100};
  localparam logic [kNItem*kTotalBits-1:0] kPriceTbl = {31'd2000, 31'd1000, 31'd500, 31'd400};
endpackage

// File: rtl/vm_change_picker.sv
// vm_change_picker: greedy selector of the largest coin not exceeding the credit
module vm_change_picker #(
  parameter int TOTAL_W = 31,
  parameter int N_COIN  = 3
) (
  input  logic [TOTAL_W-1:0]        current_total_i,
  input  logic [N_COIN*TOTAL_W-1:0] coin_value_tbl_i,
  output logic [N_COIN-1:0]         coin_o,
  output logic                      found_o
);
  // Values ascend with index, so the last qualifying entry is the largest; zero-valued coins never qualify
  always_comb begin
    coin_o  = '0;
    found_o = 1'b0;
    for (int k = 0; k < N_COIN; k++) begin
      if (coin_value_tbl_i[k*TOTAL_W +: TOTAL_W] != '0 &&
          coin_value_tbl_i[k*TOTAL_W +: TOTAL_W] <= current_total_i) begin
        coin_o    = '0;
        coin_o[k] = 1'b1;
        found_o   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vm_credit_engine.sv
// vm_credit_engine: credit register, purchase grant and greedy change return; VM_TIMEOUT_EN adds an inactivity auto-return
module vm_credit_engine
  import vending_machine_def::*;
#(
  parameter int TOTAL_W   = kTotalBits,
  parameter int N_COIN    = 3,
  parameter int N_ITEM    = 4,
  parameter int WAIT_TIME = 100
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_COIN*TOTAL_W-1:0] coin_value_tbl,
  input  logic [N_ITEM*TOTAL_W-1:0] item_price_tbl,
  input  logic [N_COIN-1:0]         i_input_coin,
  input  logic [N_ITEM-1:0]         i_select_item,
  input  logic                      i_trigger_return,
  output logic [TOTAL_W-1:0]        current_total,
  output logic [N_ITEM-1:0]         o_available_item,
  output logic [N_ITEM-1:0]         o_output_item,
  output logic [N_COIN-1:0]         o_return_coin,
  output logic                      o_reject_coin,
  output logic                      o_busy
);
  logic [1:0]         state_q, state_d;
  logic [TOTAL_W-1:0] total_q, total_d, coin_val, price, pick_val;
  logic [TOTAL_W:0]   sum;
  logic [N_ITEM-1:0]  avail, out_item_q, out_item_d;
  logic [N_COIN-1:0]  ret_coin_q, ret_coin_d, pick_coin;
  logic               reject_q, reject_d, pick_found, coin_ok, grant, go_ret, timeout;

  vm_change_picker #(.TOTAL_W(TOTAL_W), .N_COIN(N_COIN)) u_picker (
    .current_total_i (total_q),
    .coin_value_tbl_i(coin_value_tbl),
    .coin_o          (pick_coin),
    .found_o         (pick_found)
  );

  // Look up the inserted coin, selected price and picked change value; flag every affordable item
  always_comb begin
    coin_val = '0;
    price    = '0;
    pick_val = '0;
    for (int k = 0; k < N_COIN; k++) begin
      coin_val |= i_input_coin[k] ? coin_value_tbl[k*TOTAL_W +: TOTAL_W] : '0;
      pick_val |= pick_coin[k] ? coin_value_tbl[k*TOTAL_W +: TOTAL_W] : '0;
    end
    for (int j = 0; j < N_ITEM; j++) begin
      price   |= i_select_item[j] ? item_price_tbl[j*TOTAL_W +: TOTAL_W] : '0;
      avail[j] = total_q >= item_price_tbl[j*TOTAL_W +: TOTAL_W];
    end
  end

  assign sum     = {1'b0, total_q} + {1'b0, coin_val};
  assign go_ret  = state_q == kCredit && (i_trigger_return || timeout);
  assign coin_ok = state_q != kReturn && !go_ret && $onehot(i_input_coin) && !sum[TOTAL_W];
  assign grant   = state_q == kCredit && !go_ret && $onehot(i_select_item) && |(i_select_item & avail);

`ifdef VM_TIMEOUT_EN
  localparam int CntW = $clog2(WAIT_TIME + 2);
  logic [CntW-1:0] cnt_q, cnt_d;
  assign timeout = state_q == kCredit && cnt_q == '0;
  assign cnt_d   = (state_q != kCredit || coin_ok || grant) ? CntW'(WAIT_TIME) : cnt_q - CntW'(cnt_q != '0);
  // Inactivity counter restarts on any credit activity and only runs while holding credit
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= CntW'(WAIT_TIME);
    else cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Next credit and state: change ejection in RETURN, otherwise coin accept and purchase grant
  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    out_item_d = grant ? i_select_item : '0;
    ret_coin_d = '0;
    reject_d   = |i_input_coin && !coin_ok;
    if (state_q == kReturn) begin
      ret_coin_d = pick_coin;
      total_d    = pick_found ? total_q - pick_val : '0;
      state_d    = total_d == '0 ? kIdle : kReturn;
    end else if (go_ret) begin
      state_d = kReturn;
    end else begin
      total_d = (coin_ok ? sum[TOTAL_W-1:0] : total_q) - (grant ? price : '0);
      state_d = total_d == '0 ? kIdle : kCredit;
    end
  end

  // State, credit and pulse registers; reset discards any credit in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= kIdle;
      total_q    <= '0;
      out_item_q <= '0;
      ret_coin_q <= '0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      out_item_q <= out_item_d;
      ret_coin_q <= ret_coin_d;
      reject_q   <= reject_d;
    end
  end

  assign current_total    = total_q;
  assign o_available_item = state_q == kReturn ? '0 : avail;
  assign o_output_item    = out_item_q;
  assign o_return_coin    = ret_coin_q;
  assign o_reject_coin    = reject_q;
  assign o_busy           = state_q == kReturn;
endmodule

// File: tb/tb_vm_credit_engine.sv
// tb_vm_credit_engine: directed checks of credit, purchase, change return, overflow and reset
module tb_vm_credit_engine;
  import vending_machine_def::*;
  logic        clk, reset_n;
  logic [2:0]  coin, s_coin;
  logic [3:0]  sel, s_sel;
  logic        ret, s_ret;
  logic [30:0] total;
  logic [3:0]  avail, out_item;
  logic [2:0]  ret_coin;
  logic        reject, busy;
  logic [9:0]  s_total;
  logic [3:0]  s_avail, s_out_item;
  logic [2:0]  s_ret_coin;
  logic        s_reject, s_busy;
  int          checks = 0;
  int          failures = 0;

  vm_credit_engine #(.WAIT_TIME(5)) dut (
    .clk(clk), .reset_n(reset_n), .coin_value_tbl(kCoinTbl), .item_price_tbl(kPriceTbl),
    .i_input_coin(coin), .i_select_item(sel), .i_trigger_return(ret),
    .current_total(total), .o_available_item(avail), .o_output_item(out_item),
    .o_return_coin(ret_coin), .o_reject_coin(reject), .o_busy(busy)
  );

  vm_credit_engine #(.TOTAL_W(10)) dut_s (
    .clk(clk), .reset_n(reset_n), .coin_value_tbl({10'd1000, 10'd500, 10'd100}),
    .item_price_tbl({10'd1000, 10'd1000, 10'd500, 10'd400}),
    .i_input_coin(s_coin), .i_select_item(s_sel), .i_trigger_return(s_ret),
    .current_total(s_total), .o_available_item(s_avail), .o_output_item(s_out_item),
    .o_return_coin(s_ret_coin), .o_reject_coin(s_reject), .o_busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step;
    tick;
    coin = '0; sel = '0; ret = 1'b0;
    s_coin = '0; s_sel = '0; s_ret = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    coin = '0; sel = '0; ret = 1'b0;
    s_coin = '0; s_sel = '0; s_ret = 1'b0;
    repeat (2) tick;
    check("rst_total", total, 0);
    check("rst_busy", busy, 0);
    check("rst_avail", avail, 0);
    check("rst_out", out_item, 0);
    check("rst_ret", ret_coin, 0);
    check("rst_rej", reject, 0);
    reset_n = 1'b1;
    coin = 3'b010; step;
    check("ins500_total", total, 500);
    check("ins500_avail", avail, 4'b0011);
    coin = 3'b001; step;
    check("ins100_total", total, 600);
    check("ins100_avail", avail, 4'b0011);
    check("ins100_rej", reject, 0);
    sel = 4'b0001; step;
    check("buy0_out", out_item, 4'b0001);
    check("buy0_total", total, 200);
    tick;
    check("buy0_oneshot", out_item, 0);
    coin = 3'b100; step;
    coin = 3'b010; step;
    check("fill1700", total, 1700);
    ret = 1'b1; step;
    check("ret_busy0", busy, 1);
    check("ret_total0", total, 1700);
    check("ret_avail", avail, 0);
    tick;
    check("ret_c1000", ret_coin, 3'b100);
    check("ret_t700", total, 700);
    coin = 3'b001; sel = 4'b0001; step;
    check("ret_c500", ret_coin, 3'b010);
    check("ret_t200", total, 200);
    check("ret_bounce", reject, 1);
    check("ret_nosel", out_item, 0);
    tick;
    check("ret_c100a", ret_coin, 3'b001);
    check("ret_busy3", busy, 1);
    tick;
    check("ret_c100b", ret_coin, 3'b001);
    check("ret_t0", total, 0);
    check("ret_idle", busy, 0);
    tick;
    check("ret_done", ret_coin, 0);
    sel = 4'b0001; ret = 1'b1; step;
    check("idle_nosel", out_item, 0);
    check("idle_noret", busy, 0);
    repeat (4) begin coin = 3'b001; step; end
    check("fill400", total, 400);
    coin = 3'b010; sel = 4'b0010; step;
    check("precoin_out", out_item, 0);
    check("precoin_total", total, 900);
    coin = 3'b001; sel = 4'b0010; step;
    check("cs_out", out_item, 4'b0010);
    check("cs_total", total, 500);
    coin = 3'b011; step;
    check("mh_coin_rej", reject, 1);
    check("mh_coin_total", total, 500);
    sel = 4'b0011; step;
    check("mh_sel_out", out_item, 0);
    check("mh_sel_total", total, 500);
    coin = 3'b100; step;
    check("fill1500", total, 1500);
    sel = 4'b1000; step;
    check("poor_out", out_item, 0);
    check("poor_total", total, 1500);
    ret = 1'b1; coin = 3'b001; sel = 4'b0001; step;
    check("prio_rej", reject, 1);
    check("prio_out", out_item, 0);
    check("prio_busy", busy, 1);
    check("prio_total", total, 1500);
    tick;
    check("mid_c1000", ret_coin, 3'b100);
    check("mid_t500", total, 500);
    reset_n = 1'b0; tick;
    check("midrst_total", total, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ret", ret_coin, 0);
    check("midrst_rej", reject, 0);
    check("midrst_out", out_item, 0);
    reset_n = 1'b1;
    s_coin = 3'b100; step;
    check("s_fill1000", s_total, 1000);
    s_coin = 3'b001; step;
    check("s_ovf_rej", s_reject, 1);
    check("s_ovf_total", s_total, 1000);
    s_coin = 3'b001; s_sel = 4'b0001; step;
    check("s_ovfsel_rej", s_reject, 1);
    check("s_ovfsel_out", s_out_item, 4'b0001);
    check("s_ovfsel_total", s_total, 600);
`ifdef VM_TIMEOUT_EN
    coin = 3'b001; step;
    check("to_total", total, 100);
    repeat (5) tick;
    check("to_wait", busy, 0);
    tick;
    check("to_busy", busy, 1);
    tick;
    check("to_ret", ret_coin, 3'b001);
    check("to_t0", total, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
